// File: rtl/regfile_param_if.sv
// Register-file access bus: write port, two read ports and the soft-clear handshake.
// The master drives requests and the slave (the register file) returns data and status.
interface regfile_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                  regwrite;
    logic [WIDTH/8-1:0]    write_be;
    logic [ADDR_W-1:0]     write_reg;
    logic [WIDTH-1:0]      write_data;
    logic [ADDR_W-1:0]     read_reg1;
    logic [ADDR_W-1:0]     read_reg2;
    logic [WIDTH-1:0]      read_data1;
    logic [WIDTH-1:0]      read_data2;
    logic                  clear;
    logic                  busy;
    logic                  clear_done;

    modport master (
        output regwrite, write_be, write_reg, write_data, read_reg1, read_reg2, clear,
        input  read_data1, read_data2, busy, clear_done
    );

    modport slave (
        input  regwrite, write_be, write_reg, write_data, read_reg1, read_reg2, clear,
        output read_data1, read_data2, busy, clear_done
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised decode-stage register file: byte-enabled writes, optional bypass and
// hardwired zero entry, plus a one-entry-per-cycle soft-clear sweep with busy/done.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    regfile_param_if.slave bus
);
    localparam int NB = WIDTH / 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              done_q;

    logic              wr_en;
    logic [WIDTH-1:0]  wr_merged;
    logic              byp1;
    logic              byp2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Writes only land while idle; the zero entry swallows writes when hardwired.
    always_comb begin
        wr_en     = (state == S_IDLE) && bus.regwrite &&
                    !((ZERO_REG != 0) && (bus.write_reg == '0));
        wr_merged = merge_bytes(mem[bus.write_reg], bus.write_data, bus.write_be);
    end

    // The merged value is exactly what the entry holds after the edge, so it doubles as the bypass.
    always_comb begin
        byp1 = (BYPASS != 0) && wr_en && (bus.read_reg1 == bus.write_reg);
        byp2 = (BYPASS != 0) && wr_en && (bus.read_reg2 == bus.write_reg);
        rd1  = byp1 ? wr_merged : mem[bus.read_reg1];
        rd2  = byp2 ? wr_merged : mem[bus.read_reg2];
        if ((ZERO_REG != 0) && (bus.read_reg1 == '0)) rd1 = '0;
        if ((ZERO_REG != 0) && (bus.read_reg2 == '0)) rd2 = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '{default: '0};
            state  <= S_IDLE;
            ptr    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_en) mem[bus.write_reg] <= wr_merged;
                    if (bus.clear) begin
                        state <= S_SWEEP;
                        ptr   <= '0;
                    end
                end
                S_SWEEP: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + ADDR_W'(1);
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;
    assign bus.busy       = (state == S_SWEEP);
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one bypassing instance and one non-bypassing instance
// share the same stimulus; each task checks its own scenario against hand-computed values.
module tb_regfile_param;
    logic        clk;
    logic        reset_n;
    logic        regwrite;
    logic [3:0]  write_be;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        clear;

    int n_pass;
    int n_total;

    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus_a ();
    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus_b ();

    assign bus_a.regwrite   = regwrite;
    assign bus_a.write_be   = write_be;
    assign bus_a.write_reg  = write_reg;
    assign bus_a.write_data = write_data;
    assign bus_a.read_reg1  = read_reg1;
    assign bus_a.read_reg2  = read_reg2;
    assign bus_a.clear      = clear;
    assign bus_b.regwrite   = regwrite;
    assign bus_b.write_be   = write_be;
    assign bus_b.write_reg  = write_reg;
    assign bus_b.write_data = write_data;
    assign bus_b.read_reg1  = read_reg1;
    assign bus_b.read_reg2  = read_reg2;
    assign bus_b.clear      = clear;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; the rising edge in between commits them.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        regwrite = 1'b1; write_reg = a; write_data = d; write_be = be;
        @(negedge clk);
        regwrite = 1'b0; write_be = 4'h0;
    endtask

    task automatic fill_regs(input int lo);
        for (int i = lo; i < 32; i++) do_write(5'(i), {8'hA5, 8'(i), 16'hC33C}, 4'hF);
    endtask

    task automatic test_reset;
        do_write(5'd3, 32'h0BAD_F00D, 4'hF);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (bus_a.busy !== 1'b0 || bus_a.clear_done !== 1'b0)
            $display("FAIL reset_status busy=%b done=%b required 0/0", bus_a.busy, bus_a.clear_done);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            n_total++;
            if (bus_a.read_data1 !== 32'h0 || bus_a.read_data2 !== 32'h0)
                $display("FAIL reset_read r%0d p1=%h p2=%h required 0", i, bus_a.read_data1, bus_a.read_data2);
            else n_pass++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_reg1 = 5'd3;
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'h0 || bus_a.busy !== 1'b0 || bus_a.clear_done !== 1'b0)
            $display("FAIL reset_after r3=%h busy=%b done=%b required 0/0/0",
                     bus_a.read_data1, bus_a.busy, bus_a.clear_done);
        else n_pass++;
    endtask

    task automatic test_byte_write;
        do_write(5'd5, 32'hDEAD_BEEF, 4'hF);
        do_write(5'd5, 32'h1122_3344, 4'b0101);
        read_reg1 = 5'd5; read_reg2 = 5'd5;
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'hDE22_BE44 || bus_a.read_data2 !== 32'hDE22_BE44)
            $display("FAIL byte_write r5 p1=%h p2=%h required DE22BE44", bus_a.read_data1, bus_a.read_data2);
        else n_pass++;
        n_total++;
        if (bus_b.read_data1 !== 32'hDE22_BE44)
            $display("FAIL byte_write_nb r5=%h required DE22BE44", bus_b.read_data1);
        else n_pass++;
        do_write(5'd5, 32'hFFFF_FFFF, 4'h0);
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'hDE22_BE44)
            $display("FAIL byte_write_be0 r5=%h required DE22BE44", bus_a.read_data1);
        else n_pass++;
        do_write(5'd0, 32'hFFFF_FFFF, 4'hF);
        read_reg1 = 5'd0;
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'h0 || bus_b.read_data1 !== 32'h0)
            $display("FAIL zero_reg r0 a=%h b=%h required 0", bus_a.read_data1, bus_b.read_data1);
        else n_pass++;
    endtask

    task automatic test_bypass;
        do_write(5'd7, 32'hAAAA_AAAA, 4'hF);
        regwrite = 1'b1; write_reg = 5'd7; write_data = 32'h1234_5678; write_be = 4'b0011;
        read_reg1 = 5'd7; read_reg2 = 5'd0;
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'hAAAA_5678)
            $display("FAIL bypass_on r7=%h required AAAA5678", bus_a.read_data1);
        else n_pass++;
        n_total++;
        if (bus_b.read_data1 !== 32'hAAAA_AAAA)
            $display("FAIL bypass_off_before r7=%h required AAAAAAAA", bus_b.read_data1);
        else n_pass++;
        @(negedge clk);
        regwrite = 1'b0; write_be = 4'h0;
        #1;
        n_total++;
        if (bus_b.read_data1 !== 32'hAAAA_5678 || bus_a.read_data1 !== 32'hAAAA_5678)
            $display("FAIL bypass_off_after b=%h a=%h required AAAA5678", bus_b.read_data1, bus_a.read_data1);
        else n_pass++;
        // Bypass never reaches a hardwired-zero entry.
        regwrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF; write_be = 4'hF;
        read_reg2 = 5'd0;
        #1;
        n_total++;
        if (bus_a.read_data2 !== 32'h0)
            $display("FAIL bypass_zero r0=%h required 0", bus_a.read_data2);
        else n_pass++;
        @(negedge clk);
        regwrite = 1'b0; write_be = 4'h0;
    endtask

    task automatic test_soft_clear;
        int k;
        fill_regs(1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        k = 0;
        while (bus_a.busy === 1'b1 && k < 100) begin
            k++;
            if (k == 2) begin
                read_reg1 = 5'd2;
                #1;
                n_total++;
                if (bus_a.read_data1 !== 32'hA502_C33C)
                    $display("FAIL sweep_r2_early r2=%h required A502C33C", bus_a.read_data1);
                else n_pass++;
            end
            if (k == 10) begin
                read_reg1 = 5'd31; read_reg2 = 5'd2;
                #1;
                n_total++;
                if (bus_a.read_data1 !== 32'hA51F_C33C)
                    $display("FAIL sweep_r31_old r31=%h required A51FC33C", bus_a.read_data1);
                else n_pass++;
                n_total++;
                if (bus_a.read_data2 !== 32'h0)
                    $display("FAIL sweep_r2_swept r2=%h required 0", bus_a.read_data2);
                else n_pass++;
            end
            n_total++;
            if (bus_a.clear_done !== 1'b0)
                $display("FAIL sweep_done_early cycle %0d clear_done=%b required 0", k, bus_a.clear_done);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (k != 32) $display("FAIL sweep_len busy cycles=%0d required 32", k);
        else n_pass++;
        n_total++;
        if (bus_a.clear_done !== 1'b1) $display("FAIL sweep_done clear_done=%b required 1", bus_a.clear_done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus_a.clear_done !== 1'b0 || bus_a.busy !== 1'b0)
            $display("FAIL sweep_done_pulse clear_done=%b busy=%b required 0/0", bus_a.clear_done, bus_a.busy);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i);
            #1;
            n_total++;
            if (bus_a.read_data1 !== 32'h0 || bus_b.read_data2 !== 32'h0)
                $display("FAIL sweep_all_zero r%0d a=%h b=%h required 0", i, bus_a.read_data1, bus_b.read_data2);
            else n_pass++;
        end
    endtask

    task automatic test_collisions;
        int k;
        fill_regs(28);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        k = 0;
        while (bus_a.busy === 1'b1 && k < 100) begin
            k++;
            regwrite = 1'b0; write_be = 4'h0; clear = 1'b0;
            if (k == 5) begin
                // r3 is already swept here, so neither bypass nor the write may show.
                regwrite = 1'b1; write_reg = 5'd3; write_data = 32'hFFFF_FFFF; write_be = 4'hF;
                read_reg1 = 5'd3;
                #1;
                n_total++;
                if (bus_a.read_data1 !== 32'h0)
                    $display("FAIL busy_no_bypass r3=%h required 0", bus_a.read_data1);
                else n_pass++;
            end
            if (k == 12) clear = 1'b1;
            @(negedge clk);
        end
        regwrite = 1'b0; write_be = 4'h0; clear = 1'b0;
        n_total++;
        if (k != 32) $display("FAIL reclear_len busy cycles=%0d required 32", k);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus_a.busy !== 1'b0) $display("FAIL reclear_no_restart busy=%b required 0", bus_a.busy);
        else n_pass++;
        read_reg1 = 5'd3; read_reg2 = 5'd30;
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'h0 || bus_a.read_data2 !== 32'h0)
            $display("FAIL busy_write_dropped r3=%h r30=%h required 0", bus_a.read_data1, bus_a.read_data2);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int k;
        int w;
        @(negedge clk);
        clear = 1'b1;
        w = 0;
        while (bus_a.clear_done !== 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
        end
        n_total++;
        if (w != 33 || bus_a.busy !== 1'b0)
            $display("FAIL b2b_first cycles to done=%0d busy=%b required 33/0", w, bus_a.busy);
        else n_pass++;
        @(negedge clk);
        clear = 1'b0;
        n_total++;
        if (bus_a.busy !== 1'b1) $display("FAIL b2b_restart busy=%b required 1", bus_a.busy);
        else n_pass++;
        k = 0;
        while (bus_a.busy === 1'b1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        n_total++;
        if (k != 32 || bus_a.clear_done !== 1'b1)
            $display("FAIL b2b_second len=%0d done=%b required 32/1", k, bus_a.clear_done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep;
        int k;
        int seen;
        fill_regs(20);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        k = 1;
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (bus_a.busy !== 1'b0 || bus_a.clear_done !== 1'b0)
            $display("FAIL rst_mid_status busy=%b done=%b required 0/0", bus_a.busy, bus_a.clear_done);
        else n_pass++;
        read_reg1 = 5'd25; read_reg2 = 5'd31;
        #1;
        n_total++;
        if (bus_a.read_data1 !== 32'h0 || bus_a.read_data2 !== 32'h0)
            $display("FAIL rst_mid_zero r25=%h r31=%h required 0", bus_a.read_data1, bus_a.read_data2);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_a.clear_done !== 1'b0 || bus_a.busy !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL rst_mid_no_done cycles with done/busy=%0d required 0", seen);
        else n_pass++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        k = 0;
        while (bus_a.busy === 1'b1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        n_total++;
        if (k != 32 || bus_a.clear_done !== 1'b1)
            $display("FAIL rst_mid_new_sweep len=%0d done=%b required 32/1", k, bus_a.clear_done);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset_n = 1'b0; regwrite = 1'b0; write_be = 4'h0; write_reg = 5'd0; write_data = 32'h0;
        read_reg1 = 5'd0; read_reg2 = 5'd0; clear = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        test_reset;
        test_byte_write;
        test_bypass;
        test_soft_clear;
        test_collisions;
        test_back_to_back;
        test_reset_mid_sweep;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout global time limit reached required completion");
        $fatal(1, "timeout");
    end
endmodule
